// File: rtl/spi_slave_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_slave_rx_if : SPI pin and byte-stream bundle for spi_slave_rx          |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface spi_slave_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_SPI_Clk;
  logic                  i_SPI_CS_n;
  logic                  i_SPI_MOSI;
  logic                  o_SPI_MISO;
  logic [DATA_WIDTH-1:0] i_TX_Byte;
  logic                  o_TX_Load;
  logic                  o_Bit;
  logic                  o_Bit_Valid;
  logic [DATA_WIDTH-1:0] o_RX_Byte;
  logic                  o_RX_Valid;
  logic                  o_Frame_Err;

  modport slave (
    input  i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI, i_TX_Byte,
    output o_SPI_MISO, o_TX_Load, o_Bit, o_Bit_Valid, o_RX_Byte, o_RX_Valid, o_Frame_Err
  );

  modport master (
    output i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI, i_TX_Byte,
    input  o_SPI_MISO, o_TX_Load, o_Bit, o_Bit_Valid, o_RX_Byte, o_RX_Valid, o_Frame_Err
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_slave_rx : SPI mode-0 slave, MSB-first RX deserialiser / TX serialiser |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module spi_slave_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  spi_slave_rx_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [1:0] c_WAIT_IDLE = 2'd0;
  localparam logic [1:0] c_IDLE      = 2'd1;
  localparam logic [1:0] c_SHIFT     = 2'd2;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, cs_prev_q;
  logic [SYNC_STAGES:0]   settle_q;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_byte_q, rx_byte_d;
  logic                  bit_q, bit_d;
  logic                  bit_valid_q, bit_valid_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_load_q, tx_load_d;
  logic                  frame_err_q, frame_err_d;

  logic w_sck, w_cs_n, w_mosi;
  logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
  logic w_settled;

  assign w_sck  = sck_sync_q[SYNC_STAGES-1];
  assign w_cs_n = cs_sync_q[SYNC_STAGES-1];
  assign w_mosi = mosi_sync_q[SYNC_STAGES-1];

  assign w_sck_rise =  w_sck & ~sck_prev_q;
  assign w_sck_fall = ~w_sck &  sck_prev_q;
  assign w_cs_rise  =  w_cs_n & ~cs_prev_q;
  assign w_cs_fall  = ~w_cs_n &  cs_prev_q;

  // The CS_n=1 reset value of the synchroniser is not a real observation of
  // an idle bus; only trust it once the chain has been refilled from the pin.
  assign w_settled = settle_q[SYNC_STAGES];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    rx_byte_d   = rx_byte_q;
    bit_d       = bit_q;
    bit_valid_d = 1'b0;
    rx_valid_d  = 1'b0;
    tx_load_d   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      c_WAIT_IDLE: begin
        if (w_settled && w_cs_n) state_d = c_IDLE;
      end
      c_IDLE: begin
        if (w_cs_fall) begin
          state_d   = c_SHIFT;
          tx_sh_d   = bus.i_TX_Byte;
          tx_load_d = 1'b1;
          cnt_d     = '0;
        end
      end
      c_SHIFT: begin
        if (w_cs_rise) begin
          state_d = c_IDLE;
          if (cnt_q != '0) frame_err_d = 1'b1;
          cnt_d = '0;
        end else if (w_sck_rise) begin
          rx_sh_d     = {rx_sh_q[DATA_WIDTH-2:0], w_mosi};
          bit_d       = w_mosi;
          bit_valid_d = 1'b1;
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_d      = '0;
            rx_byte_d  = {rx_sh_q[DATA_WIDTH-2:0], w_mosi};
            rx_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (w_sck_fall) begin
          if (cnt_q == '0) begin
            tx_sh_d   = bus.i_TX_Byte;
            tx_load_d = 1'b1;
          end else begin
            tx_sh_d = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
      default: state_d = c_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      settle_q    <= '0;
      state_q     <= c_WAIT_IDLE;
      cnt_q       <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      rx_byte_q   <= '0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_load_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.i_SPI_Clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.i_SPI_CS_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.i_SPI_MOSI};
      sck_prev_q  <= w_sck;
      cs_prev_q   <= w_cs_n;
      settle_q    <= {settle_q[SYNC_STAGES-1:0], 1'b1};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      rx_byte_q   <= rx_byte_d;
      bit_q       <= bit_d;
      bit_valid_q <= bit_valid_d;
      rx_valid_q  <= rx_valid_d;
      tx_load_q   <= tx_load_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.o_SPI_MISO  = (state_q == c_SHIFT) ? tx_sh_q[DATA_WIDTH-1] : 1'b0;
  assign bus.o_TX_Load   = tx_load_q;
  assign bus.o_Bit       = bit_q;
  assign bus.o_Bit_Valid = bit_valid_q;
  assign bus.o_RX_Byte   = rx_byte_q;
  assign bus.o_RX_Valid  = rx_valid_q;
  assign bus.o_Frame_Err = frame_err_q;
endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_slave_rx : directed bench for spi_slave_rx, SCLK at f_Clk/8         |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_spi_slave_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_slave_rx_if #(.DATA_WIDTH(8)) bus ();

  spi_slave_rx #(.DATA_WIDTH(8), .SYNC_STAGES(2)) u_dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  int          bv_cnt = 0, rv_cnt = 0, tl_cnt = 0, fe_cnt = 0, rv_alone = 0;
  logic [31:0] bits_cap = '0;
  logic [15:0] rx_hist  = '0;
  logic [31:0] miso_cap = '0;

  // Event log sampled on the falling clock edge, away from DUT updates.
  always @(negedge clk) begin
    if (bus.o_Bit_Valid) begin
      bv_cnt   = bv_cnt + 1;
      bits_cap = {bits_cap[30:0], bus.o_Bit};
    end
    if (bus.o_RX_Valid) begin
      rv_cnt  = rv_cnt + 1;
      rx_hist = {rx_hist[7:0], bus.o_RX_Byte};
      if (!bus.o_Bit_Valid) rv_alone = rv_alone + 1;
    end
    if (bus.o_TX_Load)   tl_cnt = tl_cnt + 1;
    if (bus.o_Frame_Err) fe_cnt = fe_cnt + 1;
  end

  task automatic spi_bits(input logic [31:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.i_SPI_MOSI = data[i];
      repeat (4) @(negedge clk);
      bus.i_SPI_Clk = 1'b1;
      miso_cap = {miso_cap[30:0], bus.o_SPI_MISO};
      repeat (4) @(negedge clk);
      bus.i_SPI_Clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.i_SPI_CS_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (6) @(negedge clk);
    bus.i_SPI_CS_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if ({bus.o_Bit, bus.o_Bit_Valid, bus.o_RX_Valid, bus.o_TX_Load, bus.o_Frame_Err} !== 5'b0) begin
      failed++;
      $display("FAIL reset_strobes: got %b expected 00000",
               {bus.o_Bit, bus.o_Bit_Valid, bus.o_RX_Valid, bus.o_TX_Load, bus.o_Frame_Err});
    end
    tests++;
    if (bus.o_RX_Byte !== 8'h00) begin
      failed++; $display("FAIL reset_rx_byte: got %h expected 00", bus.o_RX_Byte);
    end
    tests++;
    if (bus.o_SPI_MISO !== 1'b0) begin
      failed++; $display("FAIL reset_miso: got %b expected 0", bus.o_SPI_MISO);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single_word();
    int b_bv = bv_cnt, b_rv = rv_cnt, b_tl = tl_cnt, b_fe = fe_cnt, b_al = rv_alone;
    bus.i_TX_Byte = 8'h3C;
    cs_low();
    spi_bits(32'hA5, 8);
    cs_high();
    tests++;
    if (bv_cnt - b_bv !== 8) begin
      failed++; $display("FAIL single_bit_strobes: got %0d expected 8", bv_cnt - b_bv);
    end
    tests++;
    if (bits_cap[7:0] !== 8'hA5) begin
      failed++; $display("FAIL single_bits: got %h expected a5", bits_cap[7:0]);
    end
    tests++;
    if (rv_cnt - b_rv !== 1 || rx_hist[7:0] !== 8'hA5) begin
      failed++; $display("FAIL single_rx: got %0d strobes byte %h expected 1 strobe byte a5",
                         rv_cnt - b_rv, rx_hist[7:0]);
    end
    tests++;
    if (rv_alone - b_al !== 0) begin
      failed++; $display("FAIL single_rx_align: got %0d unaligned expected 0", rv_alone - b_al);
    end
    tests++;
    if (miso_cap[7:0] !== 8'h3C) begin
      failed++; $display("FAIL single_miso: got %h expected 3c", miso_cap[7:0]);
    end
    tests++;
    if (tl_cnt - b_tl !== 2 || fe_cnt - b_fe !== 0) begin
      failed++; $display("FAIL single_load_err: got load %0d err %0d expected load 2 err 0",
                         tl_cnt - b_tl, fe_cnt - b_fe);
    end
    tests++;
    if (bus.o_SPI_MISO !== 1'b0 || bus.o_RX_Byte !== 8'hA5) begin
      failed++; $display("FAIL single_idle: got miso %b byte %h expected miso 0 byte a5",
                         bus.o_SPI_MISO, bus.o_RX_Byte);
    end
  endtask

  task automatic test_back_to_back();
    int b_bv = bv_cnt, b_rv = rv_cnt, b_tl = tl_cnt, b_fe = fe_cnt;
    bus.i_TX_Byte = 8'h7E;
    cs_low();
    bus.i_TX_Byte = 8'h81;
    spi_bits(32'h01FF, 16);
    cs_high();
    tests++;
    if (bv_cnt - b_bv !== 16 || bits_cap[15:0] !== 16'h01FF) begin
      failed++; $display("FAIL b2b_bits: got %0d strobes bits %h expected 16 strobes bits 01ff",
                         bv_cnt - b_bv, bits_cap[15:0]);
    end
    tests++;
    if (rv_cnt - b_rv !== 2 || rx_hist !== 16'h01FF) begin
      failed++; $display("FAIL b2b_rx: got %0d strobes bytes %h expected 2 strobes bytes 01ff",
                         rv_cnt - b_rv, rx_hist);
    end
    tests++;
    if (miso_cap[15:0] !== 16'h7E81) begin
      failed++; $display("FAIL b2b_miso: got %h expected 7e81", miso_cap[15:0]);
    end
    tests++;
    if (tl_cnt - b_tl !== 3 || fe_cnt - b_fe !== 0) begin
      failed++; $display("FAIL b2b_load_err: got load %0d err %0d expected load 3 err 0",
                         tl_cnt - b_tl, fe_cnt - b_fe);
    end
  endtask

  task automatic test_abort();
    int b_rv = rv_cnt, b_fe = fe_cnt;
    bus.i_TX_Byte = 8'hF0;
    cs_low();
    spi_bits(32'h1B, 5);
    cs_high();
    tests++;
    if (fe_cnt - b_fe !== 1 || rv_cnt - b_rv !== 0) begin
      failed++; $display("FAIL abort_err: got err %0d rx %0d expected err 1 rx 0",
                         fe_cnt - b_fe, rv_cnt - b_rv);
    end
    tests++;
    if (bus.o_RX_Byte !== 8'hFF || bus.o_SPI_MISO !== 1'b0) begin
      failed++; $display("FAIL abort_hold: got byte %h miso %b expected byte ff miso 0",
                         bus.o_RX_Byte, bus.o_SPI_MISO);
    end
    b_rv = rv_cnt; b_fe = fe_cnt;
    cs_low();
    spi_bits(32'h5A, 8);
    cs_high();
    tests++;
    if (rv_cnt - b_rv !== 1 || bus.o_RX_Byte !== 8'h5A || fe_cnt - b_fe !== 0) begin
      failed++; $display("FAIL abort_recover: got rx %0d byte %h err %0d expected rx 1 byte 5a err 0",
                         rv_cnt - b_rv, bus.o_RX_Byte, fe_cnt - b_fe);
    end
  endtask

  task automatic test_reset_mid_frame();
    int b_bv, b_rv, b_tl, b_fe;
    bus.i_TX_Byte = 8'hFF;
    cs_low();
    spi_bits(32'h5, 3);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.o_RX_Byte, bus.o_SPI_MISO, bus.o_Bit, bus.o_Bit_Valid, bus.o_RX_Valid,
         bus.o_TX_Load, bus.o_Frame_Err} !== 14'h0) begin
      failed++; $display("FAIL midrst_outputs: got byte %h miso %b bit %b expected all 0",
                         bus.o_RX_Byte, bus.o_SPI_MISO, bus.o_Bit);
    end
    @(negedge clk);
    rst = 1'b0;
    b_bv = bv_cnt; b_rv = rv_cnt; b_tl = tl_cnt; b_fe = fe_cnt;
    miso_cap = '0;
    spi_bits(32'hA5, 8);
    repeat (6) @(negedge clk);
    tests++;
    if (bv_cnt - b_bv !== 0 || rv_cnt - b_rv !== 0 || tl_cnt - b_tl !== 0 || fe_cnt - b_fe !== 0) begin
      failed++; $display("FAIL midrst_quiet: got bit %0d rx %0d load %0d err %0d expected all 0",
                         bv_cnt - b_bv, rv_cnt - b_rv, tl_cnt - b_tl, fe_cnt - b_fe);
    end
    tests++;
    if (miso_cap[7:0] !== 8'h00) begin
      failed++; $display("FAIL midrst_miso: got %h expected 00", miso_cap[7:0]);
    end
    cs_high();
    tests++;
    if (fe_cnt - b_fe !== 0) begin
      failed++; $display("FAIL midrst_cs_up: got err %0d expected 0", fe_cnt - b_fe);
    end
    b_rv = rv_cnt;
    cs_low();
    spi_bits(32'hC3, 8);
    cs_high();
    tests++;
    if (rv_cnt - b_rv !== 1 || bus.o_RX_Byte !== 8'hC3) begin
      failed++; $display("FAIL midrst_recover: got rx %0d byte %h expected rx 1 byte c3",
                         rv_cnt - b_rv, bus.o_RX_Byte);
    end
  endtask

  task automatic test_outside_and_collision();
    int b_bv = bv_cnt, b_rv = rv_cnt, b_tl = tl_cnt, b_fe = fe_cnt;
    miso_cap = '0;
    spi_bits(32'hFFFF, 16);
    repeat (6) @(negedge clk);
    tests++;
    if (bv_cnt - b_bv !== 0 || tl_cnt - b_tl !== 0 || miso_cap[15:0] !== 16'h0) begin
      failed++; $display("FAIL outside_quiet: got bit %0d load %0d miso %h expected 0 0 0000",
                         bv_cnt - b_bv, tl_cnt - b_tl, miso_cap[15:0]);
    end
    b_bv = bv_cnt; b_rv = rv_cnt; b_fe = fe_cnt;
    cs_low();
    spi_bits(32'h66, 7);
    bus.i_SPI_MOSI = 1'b1;
    repeat (4) @(negedge clk);
    bus.i_SPI_Clk  = 1'b1;
    bus.i_SPI_CS_n = 1'b1;
    repeat (4) @(negedge clk);
    bus.i_SPI_Clk  = 1'b0;
    repeat (8) @(negedge clk);
    tests++;
    if (fe_cnt - b_fe !== 1 || rv_cnt - b_rv !== 0) begin
      failed++; $display("FAIL collide_err: got err %0d rx %0d expected err 1 rx 0",
                         fe_cnt - b_fe, rv_cnt - b_rv);
    end
    tests++;
    if (bv_cnt - b_bv !== 7 || bus.o_RX_Byte !== 8'hC3) begin
      failed++; $display("FAIL collide_bits: got %0d strobes byte %h expected 7 strobes byte c3",
                         bv_cnt - b_bv, bus.o_RX_Byte);
    end
  endtask

  initial begin
    bus.i_SPI_Clk  = 1'b0;
    bus.i_SPI_CS_n = 1'b1;
    bus.i_SPI_MOSI = 1'b0;
    bus.i_TX_Byte  = 8'h00;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_abort();
    test_reset_mid_frame();
    test_outside_and_collision();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
`default_nettype wire
